pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/stall/flush sequencer for the 5-stage RV32I pipeline. Drives stall/flush of the F/D/E/M/W
//  stage registers and the E-stage forwarding muxes. Sequences multi-cycle data-memory waits with a
//  timeout, after which the core halts. One instance per core, between the stage registers and datapath.
// PARAMETERS
//  MEM_TIMEOUT   64   max consecutive cycles MemReadyM may stay low during a request before error
//  CNT_W         32   width of the perf counters (PIPE_PERF_CNT_EN only)
// PORTS
//  clk          in   1   core clock, posedge
//  reset        in   1   asynchronous, active-high; clears FSM, counters, error
//  Rs1D,Rs2D    in   5   source regs in Decode
//  Rs1E,Rs2E    in   5   source regs in Execute
//  RdE          in   5   dest reg in Execute
//  ResultSrcE   in   2   2'b01 = load in Execute
//  PCSrcE       in   1   taken branch/jump resolved in Execute
//  RdM,RdW      in   5   dest regs in Memory/Writeback
//  RegWriteM    in   1   Memory-stage write enable
//  RegWriteW    in   1   Writeback-stage write enable
//  MemReqM      in   1   Memory stage issuing a data-memory access
//  MemReadyM    in   1   data memory completes access this cycle
//  StallF,StallD,StallE,StallM  out 1  hold the corresponding stage register
//  FlushD,FlushE,FlushW         out 1  load bubble (all-zero) into the corresponding stage register
//  ForwardAE,ForwardBE          out 2  00 regfile, 01 from W result, 10 from ALUResultM
//  Halt         out  1   core halted after memory timeout
//  MemErr       out  1   sticky timeout flag
// BEHAVIOUR
//  - Reset: state=RUN, wait counter=0, all outputs 0 (Forward*=00); asserts asynchronously.
//  - Forwarding (comb): ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E; else 01 if RegWriteW &
//    RdW!=0 & RdW==Rs1E; else 00. Same for ForwardBE with Rs2E. M has priority over W.
//  - Load-use (comb): lwStall = ResultSrcE==01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
//  - memWait = MemReqM & ~MemReadyM.
//  - FSM states RUN, MEM_WAIT, ERR (registered):
//    RUN: memWait -> MEM_WAIT, cnt<=1. Else stay.
//    MEM_WAIT: MemReadyM -> RUN, cnt<=0; else cnt==MEM_TIMEOUT -> ERR; else cnt<=cnt+1.
//    ERR: absorbing until reset; Halt=MemErr=1.
//  - Output priority (highest first), evaluated every cycle:
//    1 ERR: StallF/D/E/M=1, FlushW=1, FlushD/E=0.
//    2 memWait (any state): StallF/D/E/M=1, FlushW=1 (bubble into W), FlushD/E=0.
//    3 PCSrcE: FlushD=1, FlushE=1, no stalls (branch wins over load-use; the load-use
//      instruction in D is squashed).
//    4 lwStall: StallF=1, StallD=1, FlushE=1.
//    5 else all 0.
//  - Branch during mem wait: PCSrcE held by StallE; flush applied in the first cycle MemReadyM=1.
//  - MemReadyM in the same cycle as MemReqM: no stall, FSM stays RUN (zero-wait access).
//  - Counter saturates at MEM_TIMEOUT; ERR entered the cycle after cnt reaches it.
//  - Reset mid-wait: returns to RUN immediately; no residual stall.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs StallCycles[CNT_W], FlushCount[CNT_W]. StallCycles
//  +1 each cycle StallF=1; FlushCount +1 each cycle FlushE=1; both saturate at all-ones, reset to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  pipe_ctrl_pkg: state enum (RUN/MEM_WAIT/ERR), FWD_RF=2'b00/FWD_W=2'b01/FWD_M=2'b10,
//  RESULT_LOAD=2'b01, X0=5'd0.
//  Sub-module pipe_fwd_unit: combinational forwarding selects (instantiated twice, A and B).
//  Top: FSM + wait counter + priority output logic + optional perf counters.
// TESTING
//  1 Rs1E=5,RdM=5,RegWriteM=1,RdW=5,RegWriteW=1 -> ForwardAE=10; RdM=0 -> ForwardAE=01.
//  2 ResultSrcE=01,RdE=7,Rs2D=7 -> StallF=StallD=FlushE=1 one cycle; RdE=0 -> no stall.
//  3 MemReqM=1,MemReadyM=0 for 3 cycles then 1 -> Stall F/D/E/M + FlushW for 3 cycles, RUN after.
//  4 PCSrcE=1 with lwStall=1 -> FlushD=FlushE=1, StallF=StallD=0; PCSrcE during wait -> flush on release.
//  5 MemReadyM held 0 with MEM_TIMEOUT=4 -> ERR after 5th wait cycle, Halt=MemErr=1; reset -> all 0.
//  6 PIPE_PERF_CNT_EN: scenario 3 then 2 -> StallCycles=4, FlushCount=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and encodings for the pipeline hazard controller
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [1:0] FWD_RF      = 2'b00;
   localparam logic [1:0] FWD_W       = 2'b01;
   localparam logic [1:0] FWD_M       = 2'b10;
   localparam logic [1:0] RESULT_LOAD = 2'b01;
   localparam logic [4:0] X0          = 5'd0;

endpackage

// File: rtl/pipe_fwd_unit.sv
// rtl/pipe_fwd_unit.sv - E-stage operand forwarding select for one source register
module pipe_fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] RsE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   output logic [1:0] Forward
);

   // Memory stage holds the younger result, so it wins over Writeback.
   always_comb begin
      Forward = FWD_RF;
      if (RegWriteM && (RdM != X0) && (RdM == RsE))
         Forward = FWD_M;
      else if (RegWriteW && (RdW != X0) && (RdW == RsE))
         Forward = FWD_W;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward sequencer with memory-wait timeout
// Optional perf counters (StallCycles, FlushCount) are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64
`ifdef PIPE_PERF_CNT_EN
   , parameter int CNT_W = 32
`endif
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] Rs1E,
   input  logic [4:0] Rs2E,
   input  logic [4:0] RdE,
   input  logic [1:0] ResultSrcE,
   input  logic       PCSrcE,
   input  logic [4:0] RdM,
   input  logic [4:0] RdW,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemReqM,
   input  logic       MemReadyM,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       Halt,
   output logic       MemErr
`ifdef PIPE_PERF_CNT_EN
   , output logic [CNT_W-1:0] StallCycles
   , output logic [CNT_W-1:0] FlushCount
`endif
);

   localparam int             CW      = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(MEM_TIMEOUT);

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic            lw_stall;
   logic            mem_wait;

   pipe_fwd_unit u_fwd_a (
      .RsE       (Rs1E),
      .RdM       (RdM),
      .RdW       (RdW),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .Forward   (ForwardAE)
   );

   pipe_fwd_unit u_fwd_b (
      .RsE       (Rs2E),
      .RdM       (RdM),
      .RdW       (RdW),
      .RegWriteM (RegWriteM),
      .RegWriteW (RegWriteW),
      .Forward   (ForwardBE)
   );

   assign lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != X0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
   assign mem_wait = MemReqM && !MemReadyM;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      StallF  = 1'b0;
      StallD  = 1'b0;
      StallE  = 1'b0;
      StallM  = 1'b0;
      FlushD  = 1'b0;
      FlushE  = 1'b0;
      FlushW  = 1'b0;
      Halt    = (state == ERR);
      MemErr  = (state == ERR);

      case (state)
         RUN: begin
            if (mem_wait) begin
               state_n = MEM_WAIT;
               cnt_n   = CW'(1);
            end
         end
         MEM_WAIT: begin
            if (MemReadyM) begin
               state_n = RUN;
               cnt_n   = '0;
            end else if (cnt == CNT_MAX) begin
               state_n = ERR;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ERR:     state_n = ERR;
         default: state_n = RUN;
      endcase

      // A branch held in E by a memory stall is flushed on the release cycle.
      if ((state == ERR) || mem_wait) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (lw_stall) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         StallCycles <= '0;
         FlushCount  <= '0;
      end else begin
         if (StallF && (StallCycles != '1))
            StallCycles <= StallCycles + CNT_W'(1);
         if (FlushE && (FlushCount != '1))
            FlushCount <= FlushCount + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - vector table plus scoreboarded sequences for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

   typedef struct packed {
      logic [4:0]  rs1d, rs2d, rs1e, rs2e, rde;
      logic [1:0]  rsrce;
      logic        pcs;
      logic [4:0]  rdm, rdw;
      logic        rwm, rww, mreq, mrdy;
      logic [12:0] ex;
   } vec_t;

   localparam logic [6:0] SF_NONE = 7'b0000000;
   localparam logic [6:0] SF_LW   = 7'b1100010;
   localparam logic [6:0] SF_MEM  = 7'b1111001;
   localparam logic [6:0] SF_BR   = 7'b0000110;

   logic       clk, reset;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0] ResultSrcE;
   logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
   logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, Halt, MemErr;
   logic [1:0] ForwardAE, ForwardBE;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] StallCycles, FlushCount;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   logic [12:0] exp_q[$];
   vec_t        tbl[$];

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .Halt(Halt), .MemErr(MemErr)
`ifdef PIPE_PERF_CNT_EN
      , .StallCycles(StallCycles), .FlushCount(FlushCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkv(
      input logic [4:0] rs1d, input logic [4:0] rs2d, input logic [4:0] rs1e,
      input logic [4:0] rs2e, input logic [4:0] rde, input logic [1:0] rsrce,
      input logic pcs, input logic [4:0] rdm, input logic [4:0] rdw,
      input logic rwm, input logic rww, input logic mreq, input logic mrdy,
      input logic [6:0] sf, input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] hm);
      vec_t v;
      v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
      v.rsrce = rsrce; v.pcs = pcs; v.rdm = rdm; v.rdw = rdw;
      v.rwm = rwm; v.rww = rww; v.mreq = mreq; v.mrdy = mrdy;
      v.ex = {sf, fa, fb, hm};
      return v;
   endfunction

   function automatic vec_t zv(input logic mreq, input logic mrdy, input logic pcs,
                               input logic [6:0] sf, input logic [1:0] hm);
      return mkv(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, pcs, 5'd0, 5'd0,
                 1'b0, 1'b0, mreq, mrdy, sf, 2'b00, 2'b00, hm);
   endfunction

   task automatic step(input vec_t v, input string nm);
      logic [12:0] act, ex;
      Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
      ResultSrcE = v.rsrce; PCSrcE = v.pcs; RdM = v.rdm; RdW = v.rdw;
      RegWriteM = v.rwm; RegWriteW = v.rww; MemReqM = v.mreq; MemReadyM = v.mrdy;
      exp_q.push_back(v.ex);
      @(negedge clk);
      act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
             ForwardAE, ForwardBE, Halt, MemErr};
      n_vec++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL %s: got %b, scoreboard empty", nm, act);
      end else begin
         ex = exp_q.pop_front();
         if (act !== ex) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (SF/SD/SE/SM/FD/FE/FW/FA/FB/H/E)", nm, act, ex);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; ResultSrcE = '0;
      PCSrcE = 1'b0; RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemReqM = 1'b0; MemReadyM = 1'b0;

      // inputs / expected: rs1d rs2d rs1e rs2e rde rsrce pcs rdm rdw rwm rww mreq mrdy | sf fa fb hm
      tbl.push_back(zv(1'b0, 1'b0, 1'b0, SF_NONE, 2'b00));
      tbl.push_back(mkv(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, SF_NONE, 2'b10, 2'b00, 2'b00));
      tbl.push_back(mkv(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, SF_NONE, 2'b01, 2'b00, 2'b00));
      tbl.push_back(mkv(5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 2'b00, 1'b0, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, SF_NONE, 2'b00, 2'b01, 2'b00));
      tbl.push_back(mkv(5'd0, 5'd0, 5'd3, 5'd3, 5'd0, 2'b00, 1'b0, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, SF_NONE, 2'b10, 2'b10, 2'b00));
      tbl.push_back(mkv(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, SF_NONE, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mkv(5'd0, 5'd0, 5'd6, 5'd8, 5'd0, 2'b00, 1'b0, 5'd8, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, SF_NONE, 2'b00, 2'b10, 2'b00));
      tbl.push_back(mkv(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, SF_LW, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mkv(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, SF_NONE, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mkv(5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b00, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, SF_NONE, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mkv(5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, SF_LW, 2'b00, 2'b00, 2'b00));
      tbl.push_back(mkv(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, SF_BR, 2'b00, 2'b00, 2'b00));
      tbl.push_back(zv(1'b0, 1'b0, 1'b1, SF_BR, 2'b00));
      tbl.push_back(mkv(5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, SF_LW, 2'b00, 2'b00, 2'b00));
      tbl.push_back(zv(1'b1, 1'b1, 1'b0, SF_NONE, 2'b00));

      @(posedge clk);
      #1;
      step(zv(1'b0, 1'b0, 1'b0, SF_NONE, 2'b00), "reset_state");
      reset = 1'b0;

      // three wait cycles, release, idle, then a load-use stall
      for (int i = 0; i < 3; i++) step(zv(1'b1, 1'b0, 1'b0, SF_MEM, 2'b00), "mem_wait3");
      step(zv(1'b1, 1'b1, 1'b0, SF_NONE, 2'b00), "mem_release");
      step(zv(1'b0, 1'b0, 1'b0, SF_NONE, 2'b00), "mem_after");
      step(mkv(5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
               SF_LW, 2'b00, 2'b00, 2'b00), "load_use");
`ifdef PIPE_PERF_CNT_EN
      n_vec++;
      if (StallCycles !== 32'd4) begin
         n_err++;
         $display("FAIL perf_stall: got %0d expected 4", StallCycles);
      end
      n_vec++;
      if (FlushCount !== 32'd1) begin
         n_err++;
         $display("FAIL perf_flush: got %0d expected 1", FlushCount);
      end
`endif

      for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("table%0d", i));

      // branch resolved while a memory wait holds E: flush lands on release
      for (int i = 0; i < 2; i++) step(zv(1'b1, 1'b0, 1'b1, SF_MEM, 2'b00), "br_in_wait");
      step(zv(1'b1, 1'b1, 1'b1, SF_BR, 2'b00), "br_release");

      // reset mid-wait leaves no residual stall
      step(zv(1'b1, 1'b0, 1'b0, SF_MEM, 2'b00), "pre_reset_wait");
      reset = 1'b1;
      step(zv(1'b0, 1'b0, 1'b0, SF_NONE, 2'b00), "reset_mid_wait");
      reset = 1'b0;
      step(zv(1'b0, 1'b0, 1'b0, SF_NONE, 2'b00), "after_reset");

      // timeout with MEM_TIMEOUT=4: ERR after the 5th wait cycle
      for (int i = 0; i < 5; i++) step(zv(1'b1, 1'b0, 1'b0, SF_MEM, 2'b00), $sformatf("timeout_wait%0d", i));
      step(zv(1'b1, 1'b0, 1'b0, SF_MEM, 2'b11), "err_entered");
      step(mkv(5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1,
               SF_MEM, 2'b10, 2'b00, 2'b11), "err_sticky");
      reset = 1'b1;
      step(zv(1'b0, 1'b0, 1'b0, SF_NONE, 2'b00), "err_async_reset");
      reset = 1'b0;
      step(zv(1'b0, 1'b0, 1'b0, SF_NONE, 2'b00), "err_cleared");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
